rom_burst_reader: RTL and testbench

//   Parametrised synchronous ROM with a burst-read sequencer. One start request

---
 rtl/rom_burst_reader.sv | 119 +++++++++++
 tb/tb_rom_burst_reader.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/rom_burst_reader.sv
// Synchronous pattern ROM with a burst-read sequencer.
// One start request streams a run of consecutive words over a valid/ready port.
//
// state    | meaning
// S_IDLE   | waiting for start; outputs hold their last values, out_valid low
// S_STREAM | presenting words; advancing on each accepted handshake
module rom_burst_reader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] burst_len,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic              last,
  output logic              done
);

  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic {
    S_IDLE,
    S_STREAM
  } state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  count, count_nx;
  logic [CNT_W-1:0]  len_full;
  logic [ADDR_W-1:0] addr_nx, addr_inc;
  logic [DATA_W-1:0] data_nx;
  logic              last_nx, valid_nx, busy_nx, done_nx;
  logic              handshake;

  // Every nibble of a word carries the low four address bits.
  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    logic [3:0]        nib;
    logic [DATA_W-1:0] w;
    nib = 4'(a);
    w   = '0;
    for (int i = 0; i < DATA_W / 4; i++) begin
      w[4*i +: 4] = nib;
    end
    return w;
  endfunction

  // A zero length requests the full depth, which needs the extra count bit.
  assign len_full  = (burst_len == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, burst_len};
  assign addr_inc  = addr_out + ADDR_W'(1);
  assign handshake = out_valid & out_ready;

  always_comb begin
    state_nx = state;
    count_nx = count;
    addr_nx  = addr_out;
    data_nx  = data_out;
    last_nx  = last;
    valid_nx = out_valid;
    busy_nx  = busy;
    done_nx  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_STREAM;
          addr_nx  = start_addr;
          data_nx  = rom_word(start_addr);
          count_nx = len_full;
          last_nx  = (len_full == CNT_W'(1));
          valid_nx = 1'b1;
          busy_nx  = 1'b1;
        end
      end
      S_STREAM: begin
        if (handshake) begin
          if (last) begin
            state_nx = S_IDLE;
            valid_nx = 1'b0;
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
          end else begin
            addr_nx  = addr_inc;
            data_nx  = rom_word(addr_inc);
            count_nx = count - CNT_W'(1);
            last_nx  = (count == CNT_W'(2));
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      count     <= '0;
      addr_out  <= '0;
      data_out  <= '0;
      last      <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      count     <= count_nx;
      addr_out  <= addr_nx;
      data_out  <= data_nx;
      last      <= last_nx;
      out_valid <= valid_nx;
      busy      <= busy_nx;
      done      <= done_nx;
    end
  end

endmodule

// File: tb/tb_rom_burst_reader.sv
// Bench for rom_burst_reader: directed burst scenarios plus randomized bursts
// checked against an arithmetic model of the expected word sequence.
module tb_rom_burst_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start, out_ready;
  logic [3:0] start_addr, burst_len, addr_out;
  logic [7:0] data_out;
  logic       busy, out_valid, last, done;

  logic        start_w, out_ready_w;
  logic [4:0]  start_addr_w, burst_len_w, addr_out_w;
  logic [15:0] data_out_w;
  logic        busy_w, out_valid_w, last_w, done_w;

  int n_checks = 0;
  int n_fail   = 0;

  rom_burst_reader #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .burst_len(burst_len), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .data_out(data_out), .addr_out(addr_out),
    .last(last), .done(done)
  );

  rom_burst_reader #(.ADDR_W(5), .DATA_W(16)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start_w), .start_addr(start_addr_w),
    .burst_len(burst_len_w), .busy(busy_w), .out_valid(out_valid_w),
    .out_ready(out_ready_w), .data_out(data_out_w), .addr_out(addr_out_w),
    .last(last_w), .done(done_w)
  );

  function automatic logic [7:0] model8(input int a);
    logic [7:0] nib;
    nib = 8'(a % 16);
    return nib * 8'h11;
  endfunction

  function automatic logic [15:0] model16(input int a);
    logic [15:0] nib;
    nib = 16'(a % 16);
    return nib * 16'h1111;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where done should be high.
  // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready.
  task automatic run_burst(input int sa, input int len, input int mode, input bit poke);
    int n, idx, cyc, ea;
    bit stalled;
    logic [31:0] h_addr, h_data, h_last;
    n = (len == 0) ? 16 : len;
    idx = 0; cyc = 0; stalled = 0;
    h_addr = '0; h_data = '0; h_last = '0;
    start = 1'b1; start_addr = 4'(sa); burst_len = 4'(len);
    @(negedge clk);
    start = 1'b0;
    while (idx < n && cyc < 200) begin
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (poke && cyc == 1) begin
        start = 1'b1; start_addr = 4'((sa + 5) % 16); burst_len = 4'd3;
      end else begin
        start = 1'b0;
      end
      check("valid", 32'(out_valid), 32'd1);
      check("busy", 32'(busy), 32'd1);
      check("done_low", 32'(done), 32'd0);
      if (stalled) begin
        check("hold_addr", 32'(addr_out), h_addr);
        check("hold_data", 32'(data_out), h_data);
        check("hold_last", 32'(last), h_last);
      end
      if (out_ready) begin
        ea = (sa + idx) % 16;
        check("addr", 32'(addr_out), 32'(ea));
        check("data", 32'(data_out), 32'(model8(ea)));
        check("last", 32'(last), 32'(idx == n - 1));
        idx++;
        stalled = 0;
      end else begin
        stalled = 1;
        h_addr = 32'(addr_out); h_data = 32'(data_out); h_last = 32'(last);
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (cyc >= 200) begin
      n_checks++; n_fail++;
      $error("FAIL timeout: observed %0d words expected %0d", idx, n);
    end
    check("done", 32'(done), 32'd1);
    check("valid_end", 32'(out_valid), 32'd0);
    check("busy_end", 32'(busy), 32'd0);
  endtask

  task automatic run_wide(input int sa, input int len);
    int n, a;
    n = (len == 0) ? 32 : len;
    start_w = 1'b1; start_addr_w = 5'(sa); burst_len_w = 5'(len); out_ready_w = 1'b1;
    @(negedge clk);
    start_w = 1'b0;
    for (int i = 0; i < n; i++) begin
      a = (sa + i) % 32;
      check("w_valid", 32'(out_valid_w), 32'd1);
      check("w_addr", 32'(addr_out_w), 32'(a));
      check("w_data", 32'(data_out_w), 32'(model16(a)));
      check("w_last", 32'(last_w), 32'(i == n - 1));
      @(negedge clk);
    end
    check("w_done", 32'(done_w), 32'd1);
    check("w_busy_end", 32'(busy_w), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start_addr = '0; burst_len = '0; out_ready = 1'b0;
    start_w = 1'b0; start_addr_w = '0; burst_len_w = '0; out_ready_w = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_last", 32'(last), 32'd0);
    check("rst_addr", 32'(addr_out), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_w_valid", 32'(out_valid_w), 32'd0);
    check("rst_w_data", 32'(data_out_w), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_burst(3, 4, 0, 0);
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
    run_burst(14, 4, 0, 0);
    run_burst(0, 0, 0, 0);
    @(negedge clk);
    run_burst(5, 6, 1, 0);
    @(negedge clk);
    run_burst(9, 6, 0, 1);
    @(negedge clk);

    start = 1'b1; start_addr = 4'd2; burst_len = 4'd8; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_addr", 32'(addr_out), 32'd4);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_addr", 32'(addr_out), 32'd0);
    check("mid_rst_data", 32'(data_out), 32'd0);
    check("mid_rst_last", 32'(last), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("post_rst_done", 32'(done), 32'd0);
      check("post_rst_valid", 32'(out_valid), 32'd0);
    end
    run_burst(7, 3, 0, 0);
    @(negedge clk);

    repeat (25) begin
      run_burst(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 2, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    @(negedge clk);
    run_wide(17, 4);
    @(negedge clk);
    run_wide(30, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
